// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: op encodings and default geometry.
package alu_rs_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned OP_W        = 6;
    localparam int unsigned RS_SIZE_DEF = 8;
    localparam int unsigned ROB_W_DEF   = 4;

    // Low two bits of the op code select the instruction format.
    typedef enum logic [1:0] {
        ALU_TYPE_U = 2'd0,
        ALU_TYPE_I = 2'd1,
        ALU_TYPE_B = 2'd2,
        ALU_TYPE_R = 2'd3
    } alu_type_e;

    localparam logic [OP_W-1:0] OP_NOP = 6'h3f;

endpackage

// File: rtl/alu_rs_pick.sv
// Lowest-index set-bit finder; reports whether any bit is set and its position.
module rs_pick #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req_i[i] && !found_o) begin
                found_o = 1'b1;
                idx_o   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops, snoops two CDBs for operands,
// issues one ready op per cycle and tags the ALU result for the ALU CDB.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int unsigned RS_SIZE = RS_SIZE_DEF,
    parameter int unsigned ROB_W   = ROB_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             RoB_clear,
    input  logic             disp_valid,
    input  logic [OP_W-1:0]  disp_op,
    input  logic [XLEN-1:0]  disp_vj,
    input  logic [XLEN-1:0]  disp_vk,
    input  logic [XLEN-1:0]  disp_imm,
    input  logic             disp_qj_busy,
    input  logic [ROB_W-1:0] disp_qj,
    input  logic             disp_qk_busy,
    input  logic [ROB_W-1:0] disp_qk,
    input  logic [ROB_W-1:0] disp_tag,
    output logic             rs_full,
    input  logic             cdb0_valid,
    input  logic [ROB_W-1:0] cdb0_tag,
    input  logic [XLEN-1:0]  cdb0_val,
    input  logic             cdb1_valid,
    input  logic [ROB_W-1:0] cdb1_tag,
    input  logic [XLEN-1:0]  cdb1_val,
    output logic [OP_W-1:0]  alu_op,
    output logic [XLEN-1:0]  alu_vj,
    output logic [XLEN-1:0]  alu_vk,
    output logic [XLEN-1:0]  alu_imm,
    output logic             alu_waiting,
    input  logic             alu_finish_rdy,
    input  logic [XLEN-1:0]  alu_value,
    output logic             cdb_valid,
    output logic [ROB_W-1:0] cdb_tag,
    output logic [XLEN-1:0]  cdb_val
);

    localparam int unsigned IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]            busy_q, busy_d, qj_busy_q, qj_busy_d, qk_busy_q, qk_busy_d;
    logic [RS_SIZE-1:0][OP_W-1:0]  op_q, op_d;
    logic [RS_SIZE-1:0][XLEN-1:0]  vj_q, vj_d, vk_q, vk_d, imm_q, imm_d;
    logic [RS_SIZE-1:0][ROB_W-1:0] qj_q, qj_d, qk_q, qk_d, tag_q, tag_d;
    logic                          inflight_valid_q, inflight_valid_d;
    logic [ROB_W-1:0]              inflight_tag_q, inflight_tag_d;

    logic             free_found, ready_found, issue_fire;
    logic [IDX_W-1:0] free_idx, ready_idx;

    function automatic logic hit(input logic v, input logic [ROB_W-1:0] t,
                                 input logic [ROB_W-1:0] q);
        return v && (t == q);
    endfunction

    rs_pick #(.N(RS_SIZE), .IW(IDX_W)) u_pick_free (
        .req_i   (~busy_q),
        .found_o (free_found),
        .idx_o   (free_idx)
    );

    rs_pick #(.N(RS_SIZE), .IW(IDX_W)) u_pick_ready (
        .req_i   (busy_q & ~qj_busy_q & ~qk_busy_q),
        .found_o (ready_found),
        .idx_o   (ready_idx)
    );

    assign issue_fire  = ready_found & rdy_in & ~RoB_clear;
    assign rs_full     = &busy_q;
    assign alu_op      = op_q[ready_idx];
    assign alu_vj      = vj_q[ready_idx];
    assign alu_vk      = vk_q[ready_idx];
    assign alu_imm     = imm_q[ready_idx];
    assign alu_waiting = issue_fire;
    assign cdb_valid   = alu_finish_rdy & inflight_valid_q;
    assign cdb_tag     = inflight_tag_q;
    assign cdb_val     = alu_value;

    // Next state: flush dominates, freeze holds, otherwise snoop + issue + allocate.
    always_comb begin
        busy_d           = busy_q;
        op_d             = op_q;
        vj_d             = vj_q;
        vk_d             = vk_q;
        imm_d            = imm_q;
        qj_busy_d        = qj_busy_q;
        qj_d             = qj_q;
        qk_busy_d        = qk_busy_q;
        qk_d             = qk_q;
        tag_d            = tag_q;
        inflight_valid_d = 1'b0;
        inflight_tag_d   = inflight_tag_q;

        if (RoB_clear) begin
            busy_d = '0;
        end else if (!rdy_in) begin
            inflight_valid_d = inflight_valid_q;
        end else begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i] && qj_busy_q[i]) begin
                    if (hit(cdb0_valid, cdb0_tag, qj_q[i])) begin
                        vj_d[i] = cdb0_val;  qj_busy_d[i] = 1'b0;
                    end else if (hit(cdb1_valid, cdb1_tag, qj_q[i])) begin
                        vj_d[i] = cdb1_val;  qj_busy_d[i] = 1'b0;
                    end
                end
                if (busy_q[i] && qk_busy_q[i]) begin
                    if (hit(cdb0_valid, cdb0_tag, qk_q[i])) begin
                        vk_d[i] = cdb0_val;  qk_busy_d[i] = 1'b0;
                    end else if (hit(cdb1_valid, cdb1_tag, qk_q[i])) begin
                        vk_d[i] = cdb1_val;  qk_busy_d[i] = 1'b0;
                    end
                end
            end

            if (ready_found) begin
                busy_d[ready_idx] = 1'b0;
                inflight_valid_d  = 1'b1;
                inflight_tag_d    = tag_q[ready_idx];
            end

            // Free slot comes from registered busy, so it never collides with the issuing entry.
            if (disp_valid && free_found) begin
                busy_d[free_idx] = 1'b1;
                op_d[free_idx]   = disp_op;
                imm_d[free_idx]  = disp_imm;
                tag_d[free_idx]  = disp_tag;
                qj_d[free_idx]   = disp_qj;
                qk_d[free_idx]   = disp_qk;
                if (disp_qj_busy && hit(cdb0_valid, cdb0_tag, disp_qj)) begin
                    vj_d[free_idx] = cdb0_val;  qj_busy_d[free_idx] = 1'b0;
                end else if (disp_qj_busy && hit(cdb1_valid, cdb1_tag, disp_qj)) begin
                    vj_d[free_idx] = cdb1_val;  qj_busy_d[free_idx] = 1'b0;
                end else begin
                    vj_d[free_idx] = disp_vj;   qj_busy_d[free_idx] = disp_qj_busy;
                end
                if (disp_qk_busy && hit(cdb0_valid, cdb0_tag, disp_qk)) begin
                    vk_d[free_idx] = cdb0_val;  qk_busy_d[free_idx] = 1'b0;
                end else if (disp_qk_busy && hit(cdb1_valid, cdb1_tag, disp_qk)) begin
                    vk_d[free_idx] = cdb1_val;  qk_busy_d[free_idx] = 1'b0;
                end else begin
                    vk_d[free_idx] = disp_vk;   qk_busy_d[free_idx] = disp_qk_busy;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q           <= '0;
            op_q             <= '0;
            vj_q             <= '0;
            vk_q             <= '0;
            imm_q            <= '0;
            qj_busy_q        <= '0;
            qj_q             <= '0;
            qk_busy_q        <= '0;
            qk_q             <= '0;
            tag_q            <= '0;
            inflight_valid_q <= 1'b0;
            inflight_tag_q   <= '0;
        end else begin
            busy_q           <= busy_d;
            op_q             <= op_d;
            vj_q             <= vj_d;
            vk_q             <= vk_d;
            imm_q            <= imm_d;
            qj_busy_q        <= qj_busy_d;
            qj_q             <= qj_d;
            qk_busy_q        <= qk_busy_d;
            qk_q             <= qk_d;
            tag_q            <= tag_d;
            inflight_valid_q <= inflight_valid_d;
            inflight_tag_q   <= inflight_tag_d;
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs with a one-cycle ALU model behind it.
module tb_alu_rs;

    logic        clk, rst_n, rdy_in, RoB_clear;
    logic        disp_valid, disp_qj_busy, disp_qk_busy;
    logic [5:0]  disp_op;
    logic [31:0] disp_vj, disp_vk, disp_imm;
    logic [3:0]  disp_qj, disp_qk, disp_tag;
    logic        rs_full;
    logic        cdb0_valid, cdb1_valid;
    logic [3:0]  cdb0_tag, cdb1_tag;
    logic [31:0] cdb0_val, cdb1_val;
    logic [5:0]  alu_op;
    logic [31:0] alu_vj, alu_vk, alu_imm;
    logic        alu_waiting;
    logic        alu_finish_rdy;
    logic [31:0] alu_value;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_val;

    int n_checks = 0;
    int n_pass   = 0;

    alu_rs dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy_in), .RoB_clear(RoB_clear),
        .disp_valid(disp_valid), .disp_op(disp_op), .disp_vj(disp_vj), .disp_vk(disp_vk),
        .disp_imm(disp_imm), .disp_qj_busy(disp_qj_busy), .disp_qj(disp_qj),
        .disp_qk_busy(disp_qk_busy), .disp_qk(disp_qk), .disp_tag(disp_tag),
        .rs_full(rs_full),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_val(cdb0_val),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_val(cdb1_val),
        .alu_op(alu_op), .alu_vj(alu_vj), .alu_vk(alu_vk), .alu_imm(alu_imm),
        .alu_waiting(alu_waiting), .alu_finish_rdy(alu_finish_rdy), .alu_value(alu_value),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: NOP -> 0, R-type -> vj+vk, otherwise vj+imm.
    function automatic logic [31:0] alu_ref(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] imm);
        if (op == 6'h3f)       return 32'd0;
        if (op[1:0] == 2'd3)   return a + b;
        return a + imm;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_finish_rdy <= 1'b0;
            alu_value      <= 32'd0;
        end else if (rdy_in) begin
            alu_finish_rdy <= alu_waiting;
            alu_value      <= alu_ref(alu_op, alu_vj, alu_vk, alu_imm);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb0_valid = 1'b0;
        cdb1_valid = 1'b0;
    endtask

    task automatic disp(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                        input logic [31:0] imm, input logic qjb, input logic [3:0] qj,
                        input logic qkb, input logic [3:0] qk, input logic [3:0] tag);
        disp_valid   = 1'b1;
        disp_op      = op;
        disp_vj      = vj;
        disp_vk      = vk;
        disp_imm     = imm;
        disp_qj_busy = qjb;
        disp_qj      = qj;
        disp_qk_busy = qkb;
        disp_qk      = qk;
        disp_tag     = tag;
    endtask

    initial begin
        rst_n = 1'b0; rdy_in = 1'b1; RoB_clear = 1'b0;
        disp_valid = 1'b0; disp_op = '0; disp_vj = '0; disp_vk = '0; disp_imm = '0;
        disp_qj_busy = 1'b0; disp_qj = '0; disp_qk_busy = 1'b0; disp_qk = '0; disp_tag = '0;
        cdb0_valid = 1'b0; cdb0_tag = '0; cdb0_val = '0;
        cdb1_valid = 1'b0; cdb1_tag = '0; cdb1_val = '0;

        // 1. reset, then addi 5+7 with tag 3
        repeat (3) tick();
        check("rst_full",    32'(rs_full), 32'd0);
        check("rst_waiting", 32'(alu_waiting), 32'd0);
        check("rst_cdb",     32'(cdb_valid), 32'd0);
        check("rst_tag",     32'(cdb_tag), 32'd0);
        rst_n = 1'b1;
        disp(6'h05, 32'd5, 32'd0, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
        tick(); idle(); #1;
        check("t1_waiting", 32'(alu_waiting), 32'd1);
        check("t1_op",      32'(alu_op), 32'h05);
        check("t1_vj",      alu_vj, 32'd5);
        check("t1_imm",     alu_imm, 32'd7);
        tick();
        check("t1_cdb_v",   32'(cdb_valid), 32'd1);
        check("t1_cdb_tag", 32'(cdb_tag), 32'd3);
        check("t1_cdb_val", cdb_val, 32'd12);
        check("t1_idle",    32'(alu_waiting), 32'd0);
        tick();
        check("t1_cdb_off", 32'(cdb_valid), 32'd0);

        // 2. wait on qj=2 until cdb1 broadcasts 40; result 41
        disp(6'h03, 32'd0, 32'd1, 32'd0, 1'b1, 4'd2, 1'b0, 4'd0, 4'd4);
        tick(); idle(); #1;
        check("t2_blocked0", 32'(alu_waiting), 32'd0);
        tick();
        check("t2_blocked1", 32'(alu_waiting), 32'd0);
        cdb1_valid = 1'b1; cdb1_tag = 4'd2; cdb1_val = 32'd40;
        tick(); idle(); #1;
        check("t2_waiting", 32'(alu_waiting), 32'd1);
        check("t2_vj",      alu_vj, 32'd40);
        tick();
        check("t2_cdb_tag", 32'(cdb_tag), 32'd4);
        check("t2_cdb_val", cdb_val, 32'd41);
        check("t2_cdb_v",   32'(cdb_valid), 32'd1);

        // 3. wake-up on the dispatch edge itself
        disp(6'h03, 32'd0, 32'd2, 32'd0, 1'b1, 4'd6, 1'b0, 4'd0, 4'd5);
        cdb0_valid = 1'b1; cdb0_tag = 4'd6; cdb0_val = 32'd9;
        tick(); idle(); #1;
        check("t3_waiting", 32'(alu_waiting), 32'd1);
        check("t3_vj",      alu_vj, 32'd9);
        tick();
        check("t3_cdb_tag", 32'(cdb_tag), 32'd5);
        check("t3_cdb_val", cdb_val, 32'd11);

        // 4. fill all 8 entries blocked on tags 8..15
        for (int i = 0; i < 8; i++) begin
            disp(6'h03, 32'd0, 32'(i), 32'd0, 1'b1, 4'(i + 8), 1'b0, 4'd0, 4'(i));
            tick();
        end
        idle(); #1;
        check("t4_full",    32'(rs_full), 32'd1);
        check("t4_blocked", 32'(alu_waiting), 32'd0);
        cdb0_valid = 1'b1; cdb0_tag = 4'd13; cdb0_val = 32'd100;
        cdb1_valid = 1'b1; cdb1_tag = 4'd10; cdb1_val = 32'd200;
        tick(); idle(); #1;
        check("t4_first_vj", alu_vj, 32'd200);
        check("t4_first_vk", alu_vk, 32'd2);
        check("t4_still_full", 32'(rs_full), 32'd1);
        tick();
        check("t4_second_vj", alu_vj, 32'd100);
        check("t4_second_vk", alu_vk, 32'd5);
        check("t4_not_full",  32'(rs_full), 32'd0);
        check("t4_cdb_tag2",  32'(cdb_tag), 32'd2);
        check("t4_cdb_val2",  cdb_val, 32'd202);
        tick();
        check("t4_cdb_tag5",  32'(cdb_tag), 32'd5);
        check("t4_cdb_val5",  cdb_val, 32'd105);
        check("t4_drained",   32'(alu_waiting), 32'd0);

        // 5. two ops in flight, then flush
        cdb0_valid = 1'b1; cdb0_tag = 4'd8; cdb0_val = 32'd1;
        cdb1_valid = 1'b1; cdb1_tag = 4'd9; cdb1_val = 32'd2;
        tick(); idle(); #1;
        check("t5_issue0", alu_vj, 32'd1);
        tick();
        check("t5_issue1", alu_vj, 32'd2);
        check("t5_cdb0",   32'(cdb_tag), 32'd0);
        RoB_clear = 1'b1; #1;
        check("t5_clear_no_issue", 32'(alu_waiting), 32'd0);
        tick();
        RoB_clear = 1'b0; #1;
        check("t5_not_full", 32'(rs_full), 32'd0);
        check("t5_no_cdb",   32'(cdb_valid), 32'd0);
        check("t5_empty",    32'(alu_waiting), 32'd0);
        cdb0_valid = 1'b1; cdb0_tag = 4'd11; cdb0_val = 32'd5;
        tick(); idle(); #1;
        check("t5_gone", 32'(alu_waiting), 32'd0);

        // 6. freeze with a ready entry for 4 cycles; dispatch during freeze is ignored
        disp(6'h05, 32'd20, 32'd0, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7);
        tick(); idle(); #1;
        check("t6_ready", 32'(alu_waiting), 32'd1);
        rdy_in = 1'b0;
        disp(6'h05, 32'd50, 32'd0, 32'd50, 1'b0, 4'd0, 1'b0, 4'd0, 4'd8);
        #1;
        check("t6_gated", 32'(alu_waiting), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_hold_vj", alu_vj, 32'd20);
            check("t6_hold_cdb", 32'(cdb_valid), 32'd0);
        end
        idle();
        rdy_in = 1'b1; #1;
        check("t6_release", 32'(alu_waiting), 32'd1);
        tick();
        check("t6_cdb_tag", 32'(cdb_tag), 32'd7);
        check("t6_cdb_val", cdb_val, 32'd23);
        check("t6_one_issue", 32'(alu_waiting), 32'd0);
        tick();
        check("t6_one_cdb", 32'(cdb_valid), 32'd0);

        // NOP broadcasts zero with its tag
        disp(6'h3f, 32'd9, 32'd9, 32'd9, 1'b0, 4'd0, 1'b0, 4'd0, 4'd10);
        tick(); idle(); tick();
        check("nop_tag", 32'(cdb_tag), 32'd10);
        check("nop_val", cdb_val, 32'd0);

        // async reset mid-operation
        disp(6'h05, 32'd1, 32'd0, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
        tick(); idle(); #1;
        check("ar_ready", 32'(alu_waiting), 32'd1);
        rst_n = 1'b0; #1;
        check("ar_cleared", 32'(alu_waiting), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("ar_no_cdb", 32'(cdb_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
